// File: rtl/wb_trace_pkg.sv
// Shared types for the Wishbone trace FIFO: FIFO entry layout, drain states, record bit positions.
// WB_TRACE_ADDR_EN widens the entry with the snooped address so an address record can be emitted.
package wb_trace_pkg;

  localparam int ADDR_FLAG_BIT = 33;
  localparam int WE_BIT        = 32;
  localparam int REC_W         = 34;

`ifdef WB_TRACE_ADDR_EN
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
  } entry_t;
`else
  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } entry_t;
`endif

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACC  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } drain_state_e;

  function automatic logic [REC_W-1:0] make_rec(input logic addr_flag, input logic we,
                                                input logic [31:0] payload);
    logic [REC_W-1:0] r;
    r                = '0;
    r[ADDR_FLAG_BIT] = addr_flag;
    r[WE_BIT]        = we;
    r[31:0]          = payload;
    return r;
  endfunction

endpackage

// File: rtl/wb_trace_sfifo.sv
// Single-clock synchronous FIFO; pointers carry an extra MSB to tell full from empty.
// A push on a full FIFO is accepted only when a pop frees the slot in the same cycle.
module wb_trace_sfifo
  import wb_trace_pkg::*;
#(
  parameter int WIDTH      = 33,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/wb_trace_fifo.sv
// Passive Wishbone tracer: captures completed transfers into a FIFO and drains them to the UART hex printer.
// Define WB_TRACE_ADDR_EN to emit an address record ahead of each data record.
//
// state        | meaning
// ST_IDLE      | waiting for a queued entry and printer not busy; latch head and pop
// ST_ISSUE     | drive the one-cycle record strobe
// ST_WAIT_ACC  | wait for the printer to raise stall
// ST_WAIT_DONE | wait for the printer to drop stall
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DROP_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_wb_cyc,
  input  logic                  in_wb_stb,
  input  logic                  in_wb_we,
  input  logic [31:0]           in_wb_adr,
  input  logic [31:0]           in_wb_dat_w,
  input  logic [31:0]           in_wb_dat_r,
  input  logic                  in_wb_ack,
  output logic [REC_W-1:0]      out_WB2UART_word,
  output logic                  out_WB2UART_cyc,
  input  logic                  in_WB2UART_stall,
  output logic [DEPTH_LOG2:0]   out_level,
  output logic                  out_overflow,
  output logic [DROP_W-1:0]     out_drop_cnt
);

  localparam int ENTRY_W = $bits(entry_t);

  entry_t       cap_entry;
  entry_t       head;
  logic         cap;
  logic         pop;
  logic         drop;
  logic         fifo_full;
  logic         fifo_empty;
  drain_state_e state;

`ifdef WB_TRACE_ADDR_EN
  logic [REC_W-1:0] data_rec_hold;
  logic             data_pend;
`else
  logic             unused_adr;
  assign unused_adr = ^in_wb_adr;
`endif

  assign cap = in_wb_cyc & in_wb_stb & in_wb_ack;

  always_comb begin
    cap_entry      = '0;
    cap_entry.we   = in_wb_we;
    cap_entry.data = in_wb_we ? in_wb_dat_w : in_wb_dat_r;
`ifdef WB_TRACE_ADDR_EN
    cap_entry.adr  = in_wb_adr;
`endif
  end

  assign pop  = (state == ST_IDLE) & ~fifo_empty & ~in_WB2UART_stall;
  assign drop = cap & fifo_full & ~pop;

  wb_trace_sfifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .pop   (pop),
    .din   (cap_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (out_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_drop_cnt <= '0;
      out_overflow <= 1'b0;
    end else if (drop) begin
      out_overflow <= 1'b1;
      if (out_drop_cnt != '1) out_drop_cnt <= out_drop_cnt + DROP_W'(1);
    end
  end

  // Gating on stall keeps the strobe off whenever the printer reports busy.
  assign out_WB2UART_cyc = (state == ST_ISSUE) & ~in_WB2UART_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      out_WB2UART_word <= '0;
`ifdef WB_TRACE_ADDR_EN
      data_rec_hold    <= '0;
      data_pend        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
`ifdef WB_TRACE_ADDR_EN
            out_WB2UART_word <= make_rec(1'b1, head.we, head.adr);
            data_rec_hold    <= make_rec(1'b0, head.we, head.data);
            data_pend        <= 1'b1;
`else
            out_WB2UART_word <= make_rec(1'b0, head.we, head.data);
`endif
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!in_WB2UART_stall) state <= ST_WAIT_ACC;
        end
        ST_WAIT_ACC: begin
          if (in_WB2UART_stall) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!in_WB2UART_stall) begin
`ifdef WB_TRACE_ADDR_EN
            if (data_pend) begin
              out_WB2UART_word <= data_rec_hold;
              data_pend        <= 1'b0;
              state            <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
`else
            state <= ST_IDLE;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo with a printer model that raises stall for two cycles per record.
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_wb_cyc, in_wb_stb, in_wb_we, in_wb_ack;
  logic [31:0] in_wb_adr, in_wb_dat_w, in_wb_dat_r;
  logic [33:0] out_WB2UART_word;
  logic        out_WB2UART_cyc;
  logic        in_WB2UART_stall;
  logic [4:0]  out_level;
  logic        out_overflow;
  logic [15:0] out_drop_cnt;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  logic        force_stall;
  int          busy_cnt;
  int          cycle = 0;
  int          pulses = 0;
  int          viol = 0;
  logic [33:0] rec_q[$];
  int          rec_t[$];

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH_LOG2(4), .DROP_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_wb_cyc        (in_wb_cyc),
    .in_wb_stb        (in_wb_stb),
    .in_wb_we         (in_wb_we),
    .in_wb_adr        (in_wb_adr),
    .in_wb_dat_w      (in_wb_dat_w),
    .in_wb_dat_r      (in_wb_dat_r),
    .in_wb_ack        (in_wb_ack),
    .out_WB2UART_word (out_WB2UART_word),
    .out_WB2UART_cyc  (out_WB2UART_cyc),
    .in_WB2UART_stall (in_WB2UART_stall),
    .out_level        (out_level),
    .out_overflow     (out_overflow),
    .out_drop_cnt     (out_drop_cnt)
  );

  assign in_WB2UART_stall = force_stall | (busy_cnt != 0);

  always @(posedge clk) cycle <= cycle + 1;

  // Printer model: accepts a record on cyc, then is busy for two cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= 0;
    end else if (out_WB2UART_cyc) begin
      rec_q.push_back(out_WB2UART_word);
      rec_t.push_back(cycle);
      pulses <= pulses + 1;
      if (in_WB2UART_stall) viol <= viol + 1;
      busy_cnt <= 2;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic set_ack(input logic we, input logic [31:0] adr,
                         input logic [31:0] dw, input logic [31:0] dr);
    in_wb_cyc = 1'b1; in_wb_stb = 1'b1; in_wb_ack = 1'b1;
    in_wb_we = we; in_wb_adr = adr; in_wb_dat_w = dw; in_wb_dat_r = dr;
  endtask

  task automatic clear_bus();
    in_wb_cyc = 1'b0; in_wb_stb = 1'b0; in_wb_ack = 1'b0;
    in_wb_we = 1'b0; in_wb_adr = '0; in_wb_dat_w = '0; in_wb_dat_r = '0;
  endtask

  // Waits until the drain side has been quiet for four consecutive cycles.
  task automatic wait_idle(input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (out_level == 0 && !in_WB2UART_stall && !out_WB2UART_cyc) quiet++;
      else quiet = 0;
    end
    chk_cnt++;
    if (quiet < 4) $display("FAIL wait_idle: timed out after %0d cycles, level=%0d", n, out_level);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; force_stall = 1'b0; clear_bus();
    repeat (3) @(negedge clk);
    chk_cnt++; if (out_WB2UART_word !== 34'h0) $display("FAIL rst_word: got %h want 0", out_WB2UART_word); else pass_cnt++;
    chk_cnt++; if (out_WB2UART_cyc !== 1'b0) $display("FAIL rst_cyc: got %b want 0", out_WB2UART_cyc); else pass_cnt++;
    chk_cnt++; if (out_level !== 5'd0) $display("FAIL rst_level: got %0d want 0", out_level); else pass_cnt++;
    chk_cnt++; if (out_overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", out_overflow); else pass_cnt++;
    chk_cnt++; if (out_drop_cnt !== 16'd0) $display("FAIL rst_drop: got %0d want 0", out_drop_cnt); else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    int p0 = pulses;
    @(negedge clk); set_ack(1'b1, 32'h10, 32'hDEADBEEF, 32'h0BAD0BAD);
    @(negedge clk); clear_bus();
    chk_cnt++; if (out_level !== 5'd1) $display("FAIL wr_level: got %0d want 1", out_level); else pass_cnt++;
    chk_cnt++; if (out_WB2UART_cyc !== 1'b0) $display("FAIL wr_cyc_early: got %b want 0", out_WB2UART_cyc); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (out_WB2UART_cyc !== 1'b1) $display("FAIL wr_cyc: got %b want 1", out_WB2UART_cyc); else pass_cnt++;
    chk_cnt++; if (out_WB2UART_word !== 34'h1_DEADBEEF) $display("FAIL wr_word: got %h want 1deadbeef", out_WB2UART_word); else pass_cnt++;
    wait_idle(50);
    chk_cnt++; if (pulses - p0 !== 1) $display("FAIL wr_pulses: got %0d want 1", pulses - p0); else pass_cnt++;
  endtask

  task automatic test_back_to_back_read();
    int b = rec_q.size();
    @(negedge clk); set_ack(1'b0, 32'h20, 32'hFFFFFFFF, 32'h00000123);
    @(negedge clk); set_ack(1'b0, 32'h24, 32'hFFFFFFFF, 32'h00000456);
    @(negedge clk); clear_bus();
    chk_cnt++; if (out_WB2UART_cyc !== 1'b1) $display("FAIL rd_cyc: got %b want 1", out_WB2UART_cyc); else pass_cnt++;
    chk_cnt++; if (out_WB2UART_word !== 34'h0_00000123) $display("FAIL rd_word: got %h want 000000123", out_WB2UART_word); else pass_cnt++;
    chk_cnt++; if (out_level !== 5'd1) $display("FAIL rd_level: got %0d want 1", out_level); else pass_cnt++;
    wait_idle(80);
    chk_cnt++;
    if (rec_q.size() - b !== 2) $display("FAIL rd_count: got %0d want 2", rec_q.size() - b);
    else begin
      pass_cnt++;
      chk_cnt++; if (rec_q[b+1] !== 34'h0_00000456) $display("FAIL rd_word2: got %h want 000000456", rec_q[b+1]); else pass_cnt++;
      chk_cnt++; if (rec_t[b+1] - rec_t[b] !== 5) $display("FAIL rd_spacing: got %0d want 5", rec_t[b+1] - rec_t[b]); else pass_cnt++;
    end
    chk_cnt++; if (viol !== 0) $display("FAIL cyc_during_stall: got %0d want 0", viol); else pass_cnt++;
  endtask

  task automatic test_overflow_and_full_push_pop();
    int b = rec_q.size();
    int bad = 0;
    int slow = 0;
    logic [33:0] exp;
    @(negedge clk); force_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_ack(1'b1, i, 32'h100 + i, 32'h0);
      @(negedge clk);
    end
    clear_bus();
    chk_cnt++; if (out_level !== 5'd16) $display("FAIL ovf_level: got %0d want 16", out_level); else pass_cnt++;
    chk_cnt++; if (out_drop_cnt !== 16'd4) $display("FAIL ovf_drop: got %0d want 4", out_drop_cnt); else pass_cnt++;
    chk_cnt++; if (out_overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", out_overflow); else pass_cnt++;
    // Release stall and ack in the same cycle: IDLE pops while the full FIFO accepts.
    force_stall = 1'b0;
    set_ack(1'b1, 32'h99, 32'hA5A5A5A5, 32'h0);
    @(negedge clk); clear_bus();
    chk_cnt++; if (out_level !== 5'd16) $display("FAIL pp_level: got %0d want 16", out_level); else pass_cnt++;
    chk_cnt++; if (out_drop_cnt !== 16'd4) $display("FAIL pp_drop: got %0d want 4", out_drop_cnt); else pass_cnt++;
    wait_idle(400);
    chk_cnt++;
    if (rec_q.size() - b !== 17) $display("FAIL drain_count: got %0d want 17", rec_q.size() - b);
    else begin
      pass_cnt++;
      for (int k = 0; k < 17; k++) begin
        exp = (k < 16) ? {2'b01, 32'h100 + k} : 34'h1_A5A5A5A5;
        if (rec_q[b+k] !== exp) begin
          bad++;
          $display("FAIL drain_rec%0d: got %h want %h", k, rec_q[b+k], exp);
        end
        if (k > 0 && rec_t[b+k] - rec_t[b+k-1] < 4) slow++;
      end
      chk_cnt++; if (bad !== 0) $display("FAIL drain_order: got %0d bad records want 0", bad); else pass_cnt++;
      chk_cnt++; if (slow !== 0) $display("FAIL drain_spacing: got %0d short gaps want 0", slow); else pass_cnt++;
    end
  endtask

  task automatic test_addr_record();
    int b = rec_q.size();
    @(negedge clk); set_ack(1'b0, 32'h4, 32'h0, 32'h55);
    @(negedge clk); clear_bus();
    wait_idle(80);
`ifdef WB_TRACE_ADDR_EN
    chk_cnt++;
    if (rec_q.size() - b !== 2) $display("FAIL addr_count: got %0d want 2", rec_q.size() - b);
    else begin
      pass_cnt++;
      chk_cnt++; if (rec_q[b] !== 34'h2_00000004) $display("FAIL addr_rec: got %h want 200000004", rec_q[b]); else pass_cnt++;
      chk_cnt++; if (rec_q[b+1] !== 34'h0_00000055) $display("FAIL addr_data: got %h want 000000055", rec_q[b+1]); else pass_cnt++;
    end
`else
    chk_cnt++;
    if (rec_q.size() - b !== 1) $display("FAIL data_count: got %0d want 1", rec_q.size() - b);
    else begin
      pass_cnt++;
      chk_cnt++; if (rec_q[b] !== 34'h0_00000055) $display("FAIL data_rec: got %h want 000000055", rec_q[b]); else pass_cnt++;
    end
`endif
  endtask

  task automatic test_rst_mid_transfer();
    int p0 = pulses;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); set_ack(1'b0, 32'h40 + i, 32'h0, i);
    end
    @(negedge clk); clear_bus(); force_stall = 1'b1;
    chk_cnt++; if (out_level !== 5'd3) $display("FAIL mid_level: got %0d want 3", out_level); else pass_cnt++;
    chk_cnt++; if (pulses - p0 !== 1) $display("FAIL mid_pulses: got %0d want 1", pulses - p0); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    #1;
    chk_cnt++; if (out_level !== 5'd0) $display("FAIL mrst_level: got %0d want 0", out_level); else pass_cnt++;
    chk_cnt++; if (out_WB2UART_cyc !== 1'b0) $display("FAIL mrst_cyc: got %b want 0", out_WB2UART_cyc); else pass_cnt++;
    chk_cnt++; if (out_WB2UART_word !== 34'h0) $display("FAIL mrst_word: got %h want 0", out_WB2UART_word); else pass_cnt++;
    chk_cnt++; if (out_overflow !== 1'b0) $display("FAIL mrst_ovf: got %b want 0", out_overflow); else pass_cnt++;
    chk_cnt++; if (out_drop_cnt !== 16'd0) $display("FAIL mrst_drop: got %0d want 0", out_drop_cnt); else pass_cnt++;
    @(negedge clk); rst = 1'b0; force_stall = 1'b0;
    repeat (20) @(negedge clk);
    chk_cnt++; if (pulses - p0 !== 1) $display("FAIL post_rst_pulses: got %0d want 1", pulses - p0); else pass_cnt++;
    chk_cnt++; if (out_level !== 5'd0) $display("FAIL post_rst_level: got %0d want 0", out_level); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back_read();
    test_overflow_and_full_push_pop();
    test_addr_record();
    test_rst_mid_transfer();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
